// File: rtl/game_sequencer_pkg.sv
// Shared types and screen constants for the game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    GS_MENU   = 2'd0,
    GS_PLAY   = 2'd1,
    GS_OVER   = 2'd2,
    GS_PAUSED = 2'd3
  } game_state_t;

  localparam int unsigned EARTH         = 760;
  localparam int unsigned VISIBLE_H     = 768;
  localparam int unsigned CALC_LINE_DEF = 770;

  typedef logic [15:0] score_t;

  // Saturating add so the score sticks at 0xFFFF instead of wrapping.
  function automatic score_t score_sat_add(input score_t a, input score_t b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/game_sequencer_btn_edge_sync.sv
// Two-flop synchroniser for a raw button followed by a rising-edge pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game controller: frame strobe, MENU/PLAY/OVER FSM, scroll scheduling, score.
// Optional pause support is enabled with `define GAME_SEQUENCER_PAUSE_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned CALC_LINE     = CALC_LINE_DEF,
  parameter int unsigned LOSE_Y        = 760,
  parameter int unsigned SCROLL_LINE   = 300,
  parameter int unsigned SCROLL_FRAMES = 16,
  parameter int unsigned WORLD_SHIFT   = 4,
  parameter int unsigned OVER_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] beam_x,
  input  logic [9:0]  beam_y,
  input  logic        start_btn,
`ifdef GAME_SEQUENCER_PAUSE_EN
  input  logic        pause_btn,
`endif
  input  logic [9:0]  doodle_y,
  input  logic        doodle_fall_direction,
  input  logic        collision,
  output logic        calculation_time,
  output logic [1:0]  game_state,
  output logic        move_collision,
  output logic        scrolling,
  output logic [15:0] score
);

  localparam int unsigned CW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  game_state_t   state_q;
  logic          strobe_q, start_pend_q, move_collision_q, scrolling_q;
  logic [CW-1:0] scroll_cnt_q;
  logic [7:0]    over_cnt_q;
  score_t        score_q, score_d;
  logic          start_edge, start_now, scroll_end, trigger, beam_match;

  btn_edge_sync u_start_sync (.clk(clk), .rst(rst), .btn_i(start_btn), .edge_o(start_edge));

`ifdef GAME_SEQUENCER_PAUSE_EN
  logic pause_edge, pause_pend_q, pause_now;
  btn_edge_sync u_pause_sync (.clk(clk), .rst(rst), .btn_i(pause_btn), .edge_o(pause_edge));
  assign pause_now = pause_pend_q | pause_edge;
`endif

  assign beam_match = (beam_x == 11'd0) && (beam_y == 10'(CALC_LINE));
  assign start_now  = start_pend_q | start_edge;
  assign scroll_end = scrolling_q && (scroll_cnt_q == CW'(SCROLL_FRAMES - 1));
  // The ending strobe still sees scrolling high, so a landing there may start the next episode.
  assign trigger    = collision && doodle_fall_direction && (doodle_y < 10'(SCROLL_LINE))
                      && (!scrolling_q || scroll_end);
  assign score_d    = score_sat_add(score_q, score_t'(WORLD_SHIFT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= GS_MENU;
      strobe_q         <= 1'b0;
      start_pend_q     <= 1'b0;
      move_collision_q <= 1'b0;
      scrolling_q      <= 1'b0;
      scroll_cnt_q     <= '0;
      over_cnt_q       <= '0;
      score_q          <= '0;
`ifdef GAME_SEQUENCER_PAUSE_EN
      pause_pend_q     <= 1'b0;
`endif
    end else begin
      strobe_q <= beam_match;
      if (start_edge) start_pend_q <= 1'b1;
`ifdef GAME_SEQUENCER_PAUSE_EN
      if (pause_edge) pause_pend_q <= 1'b1;
`endif
      if (strobe_q) begin
        start_pend_q <= 1'b0;
`ifdef GAME_SEQUENCER_PAUSE_EN
        pause_pend_q <= 1'b0;
`endif
        case (state_q)
          GS_MENU: begin
            if (start_now) begin
              state_q <= GS_PLAY;
              score_q <= '0;
            end
          end
          GS_PLAY: begin
            if (doodle_y >= 10'(LOSE_Y)) begin
              state_q          <= GS_OVER;
              move_collision_q <= 1'b0;
              scrolling_q      <= 1'b0;
              scroll_cnt_q     <= '0;
              over_cnt_q       <= '0;
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            else if (pause_now) begin
              state_q <= GS_PAUSED;
            end
`endif
            else begin
              if (move_collision_q) move_collision_q <= 1'b0;
              if (scrolling_q) begin
                scroll_cnt_q <= scroll_cnt_q + 1'b1;
                score_q      <= score_d;
                if (scroll_end) scrolling_q <= 1'b0;
              end
              if (trigger) begin
                move_collision_q <= 1'b1;
                scrolling_q      <= 1'b1;
                scroll_cnt_q     <= '0;
              end
            end
          end
          GS_OVER: begin
            if ((over_cnt_q >= 8'(OVER_FRAMES)) && start_now) begin
              state_q <= GS_MENU;
            end else if (over_cnt_q != 8'hFF) begin
              over_cnt_q <= over_cnt_q + 8'd1;
            end
          end
          default: begin
`ifdef GAME_SEQUENCER_PAUSE_EN
            if (pause_now) state_q <= GS_PLAY;
`else
            state_q <= GS_MENU;
`endif
          end
        endcase
      end
    end
  end

`ifdef GAME_SEQUENCER_PAUSE_EN
  assign calculation_time = strobe_q && (state_q != GS_PAUSED);
`else
  assign calculation_time = strobe_q;
`endif
  assign game_state     = state_q;
  assign move_collision = move_collision_q;
  assign scrolling      = scrolling_q;
  assign score          = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with an expected-value queue drained at each check point.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] beam_x = '0;
  logic [9:0]  beam_y = '0;
  logic        start_btn = 1'b0;
  logic [9:0]  doodle_y = 10'd400;
  logic        doodle_fall_direction = 1'b0;
  logic        collision = 1'b0;
  logic        calculation_time;
  logic [1:0]  game_state;
  logic        move_collision;
  logic        scrolling;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int mc_strobes = 0;
  int scr_strobes = 0;
  int missed_strobes = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk(clk), .rst(rst), .beam_x(beam_x), .beam_y(beam_y), .start_btn(start_btn),
    .doodle_y(doodle_y), .doodle_fall_direction(doodle_fall_direction), .collision(collision),
    .calculation_time(calculation_time), .game_state(game_state),
    .move_collision(move_collision), .scrolling(scrolling), .score(score)
  );

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    $display("check %-16s observed=%0h expected=%0h", tag, obs, e);
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // One frame: starts and ends on a falling edge, strobe lands mid-way.
  task automatic frame();
    beam_x = 11'd0;
    beam_y = 10'd770;
    @(negedge clk);
    beam_y = 10'd0;
    if (!calculation_time) missed_strobes++;
    if (calculation_time && move_collision) mc_strobes++;
    if (calculation_time && scrolling) scr_strobes++;
    @(negedge clk);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    repeat (4) @(negedge clk);
    start_btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    expect_val(0); chk({tag, "_calc"}, 32'(calculation_time));
    expect_val(0); chk({tag, "_state"}, 32'(game_state));
    expect_val(0); chk({tag, "_mc"}, 32'(move_collision));
    expect_val(0); chk({tag, "_scroll"}, 32'(scrolling));
    expect_val(0); chk({tag, "_score"}, 32'(score));
  endtask

  initial begin
    int pulses;
    int pulse_pos_ok;
    logic [15:0] exp_score;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Beam sweep around the strobe line
    pulses = 0;
    pulse_pos_ok = 1;
    for (int y = 765; y <= 775; y++) begin
      for (int x = 0; x < 8; x++) begin
        @(negedge clk);
        if (calculation_time) begin
          pulses++;
          if (!(beam_x == 11'd0 && beam_y == 10'd770)) pulse_pos_ok = 0;
        end
        beam_x = 11'(x);
        beam_y = 10'(y);
      end
    end
    @(negedge clk);
    if (calculation_time) begin
      pulses++;
      if (!(beam_x == 11'd0 && beam_y == 10'd770)) pulse_pos_ok = 0;
    end
    beam_x = 11'd5;
    beam_y = 10'd0;
    @(negedge clk);
    expect_val(1); chk("sweep_pulses", 32'(pulses));
    expect_val(1); chk("sweep_position", 32'(pulse_pos_ok));

    // Held start button: single MENU->PLAY
    start_btn = 1'b1;
    repeat (4) @(negedge clk);
    expect_val(0); chk("menu_before", 32'(game_state));
    frame();
    expect_val(1); chk("menu_to_play", 32'(game_state));
    repeat (4) frame();
    expect_val(1); chk("play_held", 32'(game_state));
    expect_val(0); chk("play_score0", 32'(score));
    start_btn = 1'b0;

    // Scroll episode with an ignored second trigger
    doodle_y = 10'd200;
    doodle_fall_direction = 1'b1;
    collision = 1'b1;
    frame();
    collision = 1'b0;
    expect_val(1); chk("trig_mc", 32'(move_collision));
    expect_val(1); chk("trig_scroll", 32'(scrolling));
    mc_strobes = 0;
    scr_strobes = 0;
    for (int i = 1; i <= 20; i++) begin
      collision = (i == 5);
      frame();
    end
    collision = 1'b0;
    expect_val(1);  chk("mc_strobes", 32'(mc_strobes));
    expect_val(16); chk("scroll_strobes", 32'(scr_strobes));
    expect_val(64); chk("episode_score", 32'(score));
    expect_val(0);  chk("episode_mc_end", 32'(move_collision));
    expect_val(0);  chk("episode_scr_end", 32'(scrolling));

    // Asynchronous reset mid-scroll
    collision = 1'b1;
    frame();
    collision = 1'b0;
    repeat (4) frame();
    expect_val(80); chk("pre_reset_score", 32'(score));
    expect_val(1);  chk("pre_reset_scr", 32'(scrolling));
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // PLAY -> OVER, abort of a running scroll, restart window
    press_start();
    frame();
    expect_val(1); chk("restart_play", 32'(game_state));
    expect_val(0); chk("restart_score", 32'(score));
    doodle_y = 10'd200;
    collision = 1'b1;
    frame();
    collision = 1'b0;
    doodle_y = 10'd759;
    frame();
    expect_val(1); chk("y759_play", 32'(game_state));
    expect_val(4); chk("y759_score", 32'(score));
    doodle_y = 10'd760;
    frame();
    expect_val(2); chk("y760_over", 32'(game_state));
    expect_val(0); chk("abort_scroll", 32'(scrolling));
    expect_val(0); chk("abort_mc", 32'(move_collision));
    for (int k = 1; k <= 49; k++) frame();
    press_start();
    frame();
    expect_val(2); chk("over_start50", 32'(game_state));
    frame();
    expect_val(2); chk("over_no_pending", 32'(game_state));
    for (int k = 52; k <= 119; k++) frame();
    press_start();
    frame();
    expect_val(2); chk("over_start120", 32'(game_state));
    press_start();
    frame();
    expect_val(0); chk("over_start121", 32'(game_state));

    // Score saturation over many episodes
    doodle_y = 10'd200;
    doodle_fall_direction = 1'b1;
    press_start();
    frame();
    expect_val(1); chk("sat_play", 32'(game_state));
    exp_score = 16'd0;
    for (int ep = 1; ep <= 1025; ep++) begin
      collision = 1'b1;
      frame();
      collision = 1'b0;
      repeat (16) frame();
      exp_score = (32'(exp_score) + 32'd64 > 32'hFFFF) ? 16'hFFFF : exp_score + 16'd64;
      if (ep >= 1023) begin
        expect_val(32'(exp_score));
        chk($sformatf("sat_ep%0d", ep), 32'(score));
      end
    end
    expect_val(0); chk("sat_scroll_done", 32'(scrolling));
    expect_val(0); chk("missed_strobes", 32'(missed_strobes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
